// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit seven-segment scan driver with blanking and frame-synchronous updates
module seg_scan_ctrl #(
  parameter int N_DIGITS         = 2,
  parameter int DIV              = 100000,
  parameter int BLANK            = 1000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dig_en,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   control,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] CTL_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  boundary;
  logic                  in_blank_n;
  logic                  pending;
  logic [4*N_DIGITS-1:0] shadow_dig, disp_dig, disp_dig_n;
  logic [N_DIGITS-1:0]   shadow_en, disp_en, disp_en_n;
  logic [N_DIGITS-1:0]   sel;
  logic [N_DIGITS-1:0]   control_n;
  logic [6:0]            seg_n;
  logic [3:0]            nib;
  logic                  en_bit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot/frame counters and the display value that will be current after this edge
  always_comb begin
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    boundary   = 1'b0;
    disp_dig_n = disp_dig;
    disp_en_n  = disp_en;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      if (idx == IDX_LAST) begin
        idx_n    = '0;
        boundary = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
    if (boundary) begin
      if (load) begin
        disp_dig_n = digits;
        disp_en_n  = dig_en;
      end else if (pending) begin
        disp_dig_n = shadow_dig;
        disp_en_n  = shadow_en;
      end
    end
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank_n = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
      assign in_blank_n = (cnt_n < BLANK_C);
    end
  endgenerate

  // Next state and the output values registered alongside it
  always_comb begin
    state_n   = state;
    control_n = CTL_OFF;
    seg_n     = 7'h7F;
    nib       = 4'h0;
    en_bit    = 1'b0;
    sel       = '0;
    case (state)
      ST_BLANK: if (!in_blank_n) state_n = ST_ON;
      ST_ON:    if (in_blank_n)  state_n = ST_BLANK;
      default:  state_n = ST_BLANK;
    endcase
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        sel[i] = 1'b1;
        nib    = disp_dig_n[4*i +: 4];
        en_bit = disp_en_n[i];
      end
    end
    if (state_n == ST_ON && en_bit) begin
      control_n = CTL_OFF ^ sel;
      seg_n     = hex7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      shadow_dig <= '0;
      shadow_en  <= '0;
      disp_dig   <= '0;
      disp_en    <= '0;
      control    <= CTL_OFF;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      disp_dig   <= disp_dig_n;
      disp_en    <= disp_en_n;
      control    <= control_n;
      seg        <= seg_n;
      frame_tick <= boundary;
      if (load) begin
        shadow_dig <= digits;
        shadow_en  <= dig_en;
      end
      // A boundary consumes the shadow (or is bypassed by a same-cycle load)
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

endmodule
